// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester handshakes (fetch and data) and the single-port
//   memory command/response bus that the arbiter sits between.
//   slave  : arbiter side (takes requests and mem_rdata, drives grants/dones/commands)
//   master : environment side (requesters plus memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  // data requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  // memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the instruction fetch
//   requester (read only) and the data load/store requester. Round-robin
//   arbitration, one-cycle registered memory command, fixed latency count,
//   one-cycle done strobe back to the winner.
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous reset, ACTIVE-HIGH despite the name
//   bus    : mem_port_arbiter_if.slave (requester handshakes + memory bus)
// Parameters:
//   ADDR_W, DATA_W : bus widths
//   MEM_LAT        : edges from memory command to valid mem_rdata, 1..4
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight, requests sampled at the closing edge
// BUSY_I  | fetch access in flight, counting down memory latency
// BUSY_D  | data access in flight, counting down memory latency
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [2:0]        cnt_q,       cnt_d;
  logic              last_srv_q,  last_srv_d;   // 0 = fetch, 1 = data
  logic              i_gnt_q,     i_gnt_d;
  logic              d_gnt_q,     d_gnt_d;
  logic              i_done_q,    i_done_d;
  logic              d_done_q,    d_done_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Data wins unless fetch is also asking and data was served last.
  logic sel_data;
  assign sel_data = bus.d_req && !(bus.i_req && last_srv_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_srv_d  = last_srv_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          cnt_d      = 3'(MEM_LAT);
          last_srv_d = sel_data;
          mem_en_d   = 1'b1;
          if (sel_data) begin
            state_d     = S_BUSY_D;
            d_gnt_d     = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            state_d    = S_BUSY_I;
            i_gnt_d    = 1'b1;
            mem_addr_d = bus.i_addr;
          end
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        cnt_d = cnt_q - 3'd1;
        // Last count: the done cycle itself behaves as IDLE, so the next
        // grant can be decided at its closing edge.
        if (cnt_q == 3'd1) begin
          state_d  = S_IDLE;
          i_done_d = (state_q == S_BUSY_I);
          d_done_d = (state_q == S_BUSY_D);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      last_srv_q  <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_srv_q  <= last_srv_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.i_gnt     = i_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single-port synchronous memory between the instruction-fetch requester and the data load/store requester. The multicycle control unit and PC logic drive the fetch side. The load/store path drives the data side. The arbiter grants one access at a time with round-robin priority, issues a one-cycle memory command, counts the fixed memory latency, and returns a one-cycle completion strobe to the winner.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, edges from memory command to valid mem_rdata; legal range 1..4

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-high
- i_req  in  1  fetch request (read only); held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  one-cycle pulse: fetch command issued this cycle
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_W  wired to mem_rdata
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data command issued this cycle
- d_done  out  1  one-cycle pulse: access complete; d_rdata valid for loads
- d_rdata  out  DATA_W  wired to mem_rdata
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered command address
- mem_wdata  out  DATA_W  registered store data
- mem_rdata  in  DATA_W  memory read data

## Operation
- States:
  - IDLE: accepts a new request.
  - BUSY_I / BUSY_D: an access is in flight.
  - Register last_srv records the last requester served (I or D).
- IDLE arbitration at each rising edge:
  - Only one of i_req/d_req high: grant that requester.
  - Both high: grant the requester that is not last_srv.
  - Neither high: stay IDLE.
- On grant:
  - Enter BUSY_x and load latency counter cnt = MEM_LAT.
  - Update last_srv.
  - Register x_gnt=1, mem_en=1, mem_addr, and mem_we (d_we for D, 0 for I).
  - For D, also register mem_wdata = d_wdata.
  - mem_wdata is don't-care on I grants.
- BUSY_x:
  - x_gnt, mem_en and mem_we drop after one cycle.
  - mem_addr and mem_wdata hold.
  - cnt decrements each edge.
  - When cnt reaches 0, assert x_done for one cycle. This cycle is treated as IDLE: requests are sampled at its closing edge.
- Stores also produce d_done, at the same latency as loads.
- Requests raised while busy are ignored until IDLE; the requester keeps them asserted.
- A requester drops req after seeing gnt. A req still high when IDLE samples is a new access.
- Dropping req before grant is legal and produces no access.
- Reset (async, any state):
  - Go to IDLE immediately, with last_srv=I and cnt=0.
  - All outputs go to 0: i_gnt, i_done, d_gnt, d_done, mem_en, mem_we, mem_addr, mem_wdata.
  - An in-flight access is abandoned and no done is issued.
  - x_rdata follows mem_rdata; it is meaningful only with x_done.
- Because last_srv resets to I, data wins the first conflict after reset.

## Timing
- Request high in cycle 0 (state IDLE):
  - cycle 1: x_gnt=1, mem_en=1.
  - cycle 1+MEM_LAT: x_done=1, data valid.
- Earliest next grant: cycle 2+MEM_LAT.
- Throughput: one access per MEM_LAT+1 cycles.
- At most one of i_gnt/d_gnt is high in any cycle. The same holds for i_done/d_done.
- mem_en is high exactly once per grant, in the same cycle as the grant.
- No combinational path from inputs to gnt, done or mem_* outputs.

## Test plan
- Reset: pulse rst_n mid-cycle -> all outputs 0 asynchronously; state IDLE.
- Single fetch, MEM_LAT=1, i_addr=0x10, memory model word 0x00500093:
  - i_gnt, mem_en=1, mem_we=0, mem_addr=0x10 in cycle 1.
  - i_done in cycle 2 with i_rdata=0x00500093.
- Store then load, MEM_LAT=2:
  - Store: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we=1 only in the gnt cycle; d_done 2 cycles later.
  - Following load of 0x20 -> d_done with d_rdata=0xDEADBEEF.
- Conflict after reset: i_req and d_req both high and held -> grant order D, I, D, I; last_srv alternates.
- Continuous requests, MEM_LAT=3:
  - Grants every 4 cycles.
  - No cycle with two grants or two dones.
  - Grant-to-done distance is exactly 3 cycles.
- Reset during BUSY_D, MEM_LAT=3, asserted one cycle after d_gnt:
  - No d_done.
  - After release, a new i_req is granted in the next cycle.
  - Data wins the next conflict.
